pwm_deadtime: RTL
=================

PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter DT_W, default 16, dead-time counter and register width.
REQ-002 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port clr_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cs / wr_n / addr  input  1/1/2  Avalon slave select, write strobe (active-low), word address.
REQ-005 SHALL have ports wr_data / rd_data  input / output  32/32  write data; combinational read data.
REQ-006 SHALL have port pwm_in  input  2  raw PWM per channel (bit1 = A, bit0 = B), same clock domain as clk.
REQ-007 SHALL have ports gate_hi / gate_lo  output  2/2  registered high-side and low-side gate drives per channel.
REQ-008 SHALL have port fault_n  input  1  external asynchronous active-low fault, present only when the Configuration macro is defined.

Function
REQ-009 SHALL map registers as follows: addr 0 CTRL (bit0 EN; bit1 FCLR, write-1 pulse, reads 0); addr 1 DT_RISE; addr 2 DT_FALL; addr 3 STATUS (read-only, writes ignored).
REQ-010 SHALL write a register when cs=1 and wr_n=0; DT registers SHALL store wr_data[DT_W-1:0] and read back zero-extended.
REQ-011 SHALL return STATUS as: bit0 fault latched; [6:4] channel A state; [10:8] channel B state; all other bits 0.
REQ-012 SHALL run one independent FSM per channel with states OFF=0, LO_ON=1, DT_R=2, HI_ON=3, DT_F=4.
REQ-013 SHALL decode outputs from the state register: gate_hi=1 only in HI_ON, gate_lo=1 only in LO_ON, both 0 otherwise.
REQ-014 SHALL never assert gate_hi[i] and gate_lo[i] in the same cycle.
REQ-015 SHALL make the transition OFF -> DT_F when EN=1 and pwm_in=0, and OFF -> DT_R when EN=1 and pwm_in=1.
REQ-016 SHALL make the transition LO_ON -> DT_R when pwm_in=1, and HI_ON -> DT_F when pwm_in=1 goes to 0.
REQ-017 SHALL load the dead counter with DT_RISE on entry to DT_R and with DT_FALL on entry to DT_F.
REQ-018 SHALL, in a DT state, decrement the counter when it is nonzero and exit to HI_ON (DT_R) or LO_ON (DT_F) when it is 0, so both gates are low for DT+1 cycles.
REQ-019 SHALL abort dead time on input reversal: pwm_in=0 in DT_R goes to LO_ON, and pwm_in=1 in DT_F goes to HI_ON, on the next edge.
REQ-020 SHALL change gate outputs one cycle after a pwm_in change (one-edge latency).
REQ-021 SHALL, when a DT register is written during dead time, leave the running count unchanged and apply the new value at the next load.
REQ-022 SHALL move every FSM to OFF on the next edge when EN=0, from any state.

Reset
REQ-023 SHALL, on clr_n=0, immediately clear CTRL, DT_RISE, DT_FALL, the counters and the fault latch, put all FSMs in OFF, and drive gate_hi=gate_lo=0.
REQ-024 SHALL, after clr_n is released with EN=0, keep all gates low until EN is written to 1.

Configuration
REQ-025 SHALL use macro PWM_DEADTIME_FAULT_EN to control fault handling.
REQ-026 SHALL, with PWM_DEADTIME_FAULT_EN defined: synchronise fault_n through 2 flops, set the fault latch on a synchronised 0, and force all FSMs to OFF while the latch is set.
REQ-027 SHALL, with PWM_DEADTIME_FAULT_EN defined: clear the latch on FCLR only if the synchronised fault_n=1; a simultaneous fault and FCLR SHALL leave the latch set.
REQ-028 SHALL, without PWM_DEADTIME_FAULT_EN: omit the fault_n port and sync flops, and hold STATUS bit0 at 0.

Structure
REQ-029 SHALL place the state enum, register address constants and CTRL bit positions in package pwm_deadtime_pkg.
REQ-030 SHALL implement the per-channel FSM and counter as sub-module pwm_deadtime_ch, instanced twice.

Verification
REQ-031 SHALL test basic dead time: DT_RISE=3, DT_FALL=5, EN=1, pwm_in[1] 0->1 -> gate_lo[1] falls after 1 edge, gate_hi[1] rises 4 cycles later; on 1->0, gate_lo[1] rises 6 cycles after gate_hi[1] falls.
REQ-032 SHALL test zero dead time: DT_RISE=0 with an input toggle -> both gates low for exactly 1 cycle.
REQ-033 SHALL test a glitch: DT_RISE=10 with a 2-cycle pwm_in pulse -> gate_hi never asserts and gate_lo returns after the pulse; STATUS shows state 2 then 1.
REQ-034 SHALL test disable and reset mid-operation: EN=0 in HI_ON -> both gates 0 on the next edge; clr_n=0 mid-DT -> outputs 0 immediately and registers read 0.
REQ-035 SHALL test fault handling with the macro defined: fault_n=0 -> gates 0 within 3 cycles and STATUS=0x001; FCLR while fault_n=0 -> still set; fault_n=1 then FCLR -> cleared, FSM resumes via DT state.
REQ-036 SHALL test the invariant by running a random pwm_in/DT sweep of 10k cycles -> gate_hi&gate_lo==0 on every cycle.

Source files
------------

// File: rtl/pwm_deadtime_pkg.sv
// Shared types and constants for the dead-time PWM gate driver.
// State encoding, register map and CTRL/STATUS bit positions.
package pwm_deadtime_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LO_ON = 3'd1,
        ST_DT_R  = 3'd2,
        ST_HI_ON = 3'd3,
        ST_DT_F  = 3'd4
    } ch_state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_DT_RISE = 2'd1;
    localparam logic [1:0] ADDR_DT_FALL = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_FCLR_BIT = 1;

    localparam int STAT_FAULT_BIT = 0;
    localparam int STAT_A_LSB     = 4;
    localparam int STAT_B_LSB     = 8;

    function automatic logic [31:0] pack_status(
        input logic      fault,
        input ch_state_e st_a,
        input ch_state_e st_b
    );
        logic [31:0] s;
        s = '0;
        s[STAT_FAULT_BIT]            = fault;
        s[STAT_A_LSB +: 3]           = st_a;
        s[STAT_B_LSB +: 3]           = st_b;
        return s;
    endfunction

endpackage

// File: rtl/pwm_deadtime_ch.sv
// One half-bridge channel: complementary gates with programmable
// dead time on both edges, aborting dead time on input reversal.
module pwm_deadtime_ch
    import pwm_deadtime_pkg::*;
#(
    parameter int DT_W = 16
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            en_i,
    input  logic            pwm_i,
    input  logic [DT_W-1:0] dt_rise_i,
    input  logic [DT_W-1:0] dt_fall_i,
    output logic            gate_hi_o,
    output logic            gate_lo_o,
    output ch_state_e       state_o
);

    ch_state_e       state_q;
    logic [DT_W-1:0] cnt_q;
    logic            hi_q;
    logic            lo_q;

    // Channel FSM, dead counter and registered gate drives.
    // Gates are only ever set on entry to HI_ON / LO_ON, so the two
    // drives can never overlap.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else if (!en_i) begin
            state_q <= ST_OFF;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    hi_q <= 1'b0;
                    lo_q <= 1'b0;
                    if (pwm_i) begin
                        state_q <= ST_DT_R;
                        cnt_q   <= dt_rise_i;
                    end else begin
                        state_q <= ST_DT_F;
                        cnt_q   <= dt_fall_i;
                    end
                end
                ST_LO_ON: begin
                    if (pwm_i) begin
                        state_q <= ST_DT_R;
                        cnt_q   <= dt_rise_i;
                        lo_q    <= 1'b0;
                    end
                end
                ST_HI_ON: begin
                    if (!pwm_i) begin
                        state_q <= ST_DT_F;
                        cnt_q   <= dt_fall_i;
                        hi_q    <= 1'b0;
                    end
                end
                ST_DT_R: begin
                    if (!pwm_i) begin
                        state_q <= ST_LO_ON;
                        lo_q    <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_HI_ON;
                        hi_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DT_F: begin
                    if (pwm_i) begin
                        state_q <= ST_HI_ON;
                        hi_q    <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_LO_ON;
                        lo_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    hi_q    <= 1'b0;
                    lo_q    <= 1'b0;
                end
            endcase
        end
    end

    assign gate_hi_o = hi_q;
    assign gate_lo_o = lo_q;
    assign state_o   = state_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Two-channel dead-time gate driver with an Avalon-style register port.
// Optional fault input enabled by defining PWM_DEADTIME_FAULT_EN.
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int DT_W = 16
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        cs,
    input  logic        wr_n,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic [1:0]  pwm_in,
    output logic [1:0]  gate_hi,
    output logic [1:0]  gate_lo
`ifdef PWM_DEADTIME_FAULT_EN
    ,
    input  logic        fault_n
`endif
);

    logic            we;
    logic            en_q;
    logic [DT_W-1:0] dt_rise_q;
    logic [DT_W-1:0] dt_fall_q;
    logic            fault_q;
    logic            run;
    ch_state_e       st_a;
    ch_state_e       st_b;

    assign we = cs & ~wr_n;

    // Register file writes; FCLR is a pulse and is not stored.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            en_q      <= 1'b0;
            dt_rise_q <= '0;
            dt_fall_q <= '0;
        end else if (we) begin
            case (addr)
                ADDR_CTRL:    en_q      <= wr_data[CTRL_EN_BIT];
                ADDR_DT_RISE: dt_rise_q <= wr_data[DT_W-1:0];
                ADDR_DT_FALL: dt_fall_q <= wr_data[DT_W-1:0];
                default:      ;
            endcase
        end
    end

`ifdef PWM_DEADTIME_FAULT_EN
    logic fsync1_q;
    logic fsync2_q;
    logic fclr;

    assign fclr = we & (addr == ADDR_CTRL) & wr_data[CTRL_FCLR_BIT];

    // Two-flop synchroniser for the asynchronous fault input.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            fsync1_q <= 1'b1;
            fsync2_q <= 1'b1;
        end else begin
            fsync1_q <= fault_n;
            fsync2_q <= fsync1_q;
        end
    end

    // Fault latch: a live fault always wins over a clear request.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            fault_q <= 1'b0;
        end else if (!fsync2_q) begin
            fault_q <= 1'b1;
        end else if (fclr) begin
            fault_q <= 1'b0;
        end
    end

    // Gate off one edge earlier by also honouring the live fault.
    assign run = en_q & ~fault_q & fsync2_q;
`else
    assign fault_q = 1'b0;
    assign run     = en_q;
`endif

    pwm_deadtime_ch #(
        .DT_W(DT_W)
    ) u_ch_a (
        .clk      (clk),
        .clr_n    (clr_n),
        .en_i     (run),
        .pwm_i    (pwm_in[1]),
        .dt_rise_i(dt_rise_q),
        .dt_fall_i(dt_fall_q),
        .gate_hi_o(gate_hi[1]),
        .gate_lo_o(gate_lo[1]),
        .state_o  (st_a)
    );

    pwm_deadtime_ch #(
        .DT_W(DT_W)
    ) u_ch_b (
        .clk      (clk),
        .clr_n    (clr_n),
        .en_i     (run),
        .pwm_i    (pwm_in[0]),
        .dt_rise_i(dt_rise_q),
        .dt_fall_i(dt_fall_q),
        .gate_hi_o(gate_hi[0]),
        .gate_lo_o(gate_lo[0]),
        .state_o  (st_b)
    );

    // Combinational read mux.
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CTRL:    rd_data[CTRL_EN_BIT] = en_q;
            ADDR_DT_RISE: rd_data = 32'(dt_rise_q);
            ADDR_DT_FALL: rd_data = 32'(dt_fall_q);
            default:      rd_data = pack_status(fault_q, st_a, st_b);
        endcase
    end

    if (DT_W < 32) begin : g_unused
        logic unused_wr_hi;
        assign unused_wr_hi = ^wr_data[31:DT_W];
    end

endmodule
